// File: rtl/demux_pkg.sv
// Shared constants and types for the 4-lane tagged demultiplexer.
// Optional feature macro used by demux_12b: DEMUX_STATS_EN (per-lane accept counters).
package demux_pkg;

   localparam int NUM_LANES = 4;
   // Tag bit positions at the default 12-bit word width; the tag is always the top two bits.
   localparam int DEF_WIDTH = 12;
   localparam int TAG_MSB   = DEF_WIDTH - 1;
   localparam int TAG_LSB   = DEF_WIDTH - 2;
   localparam int TAG_W     = TAG_MSB - TAG_LSB + 1;
   localparam int STAT_W    = 16;

   typedef logic [TAG_W-1:0] lane_t;

endpackage

// File: rtl/demux_lane_fifo.sv
// Single-lane synchronous FIFO. Push into a full lane and pop from an empty lane
// are ignored. The head word reads as zero while empty.
module demux_lane_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] word,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // Full is evaluated before any same-edge pop, so a full lane never bypasses.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage has no reset; stale contents are hidden by the empty flag.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= word;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/demux_12b.sv
// Tagged-word demultiplexer: the top two bits of each word select one of four
// independent lane FIFOs. Optional macro DEMUX_STATS_EN adds saturating
// per-lane accepted-word counters on stat_count0..3.
module demux_12b
   import demux_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_in,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic [WIDTH-1:0] data_out3,
   output logic             valid_out0,
   output logic             valid_out1,
   output logic             valid_out2,
   output logic             valid_out3,
   input  logic             pop0,
   input  logic             pop1,
   input  logic             pop2,
   input  logic             pop3
`ifdef DEMUX_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_count0,
   output logic [STAT_W-1:0] stat_count1,
   output logic [STAT_W-1:0] stat_count2,
   output logic [STAT_W-1:0] stat_count3
`endif
);

   lane_t                             lane;
   logic                              accept;
   logic [NUM_LANES-1:0]              push;
   logic [NUM_LANES-1:0]              pop;
   logic [NUM_LANES-1:0]              full;
   logic [NUM_LANES-1:0]              empty;
   logic [NUM_LANES-1:0][WIDTH-1:0]   head;
   logic [NUM_LANES-1:0][WIDTH-1:0]   dout;
   logic [NUM_LANES-1:0]              vout;

   assign lane     = lane_t'(data_in[WIDTH-1 -: TAG_W]);
   // Readiness depends only on the addressed lane, never on valid_in.
   assign ready_in = ~full[lane];
   // Words offered during reset are dropped.
   assign accept   = valid_in && ready_in && !reset;
   assign pop      = {pop3, pop2, pop1, pop0};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign push[i] = accept && (lane == lane_t'(i));
      // Outputs are forced quiet while reset is held, before the flush edge lands.
      assign vout[i] = ~empty[i] & ~reset;
      assign dout[i] = reset ? '0 : head[i];

      demux_lane_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[i]),
         .pop   (pop[i]),
         .word  (data_in),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );
   end

   assign data_out0  = dout[0];
   assign data_out1  = dout[1];
   assign data_out2  = dout[2];
   assign data_out3  = dout[3];
   assign valid_out0 = vout[0];
   assign valid_out1 = vout[1];
   assign valid_out2 = vout[2];
   assign valid_out3 = vout[3];

`ifdef DEMUX_STATS_EN
   logic [NUM_LANES-1:0][STAT_W-1:0] stat;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_stat
      // Count accepted words per lane, holding at all-ones.
      always_ff @(posedge clk) begin
         if (reset)                                  stat[i] <= '0;
         else if (push[i] && (stat[i] != '1))        stat[i] <= stat[i] + 1'b1;
      end
   end

   assign stat_count0 = stat[0];
   assign stat_count1 = stat[1];
   assign stat_count2 = stat[2];
   assign stat_count3 = stat[3];
`endif

endmodule

// File: tb/tb_demux_12b.sv
// Scoreboard bench for demux_12b: a per-lane queue model is updated at every
// edge from the driven inputs; each test task compares DUT outputs against it.
module tb_demux_12b;

   localparam int W = 12;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  data_in = '0;
   logic          valid_in = 1'b0;
   logic [3:0]    pop_v = '0;
   logic          ready_in;
   logic [W-1:0]  data_out0, data_out1, data_out2, data_out3;
   logic          valid_out0, valid_out1, valid_out2, valid_out3;
   logic [W-1:0]  dout [4];
   logic          vout [4];

   int            checks = 0;
   int            failures = 0;
   logic [W-1:0]  mdl [4][$];
   int            cnt [4];

   always #5 clk = ~clk;

`ifdef DEMUX_STATS_EN
   logic [15:0] stat_count0, stat_count1, stat_count2, stat_count3;
   logic [15:0] sc [4];
   assign sc[0] = stat_count0;
   assign sc[1] = stat_count1;
   assign sc[2] = stat_count2;
   assign sc[3] = stat_count3;
`endif

   demux_12b #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .data_out2  (data_out2),
      .data_out3  (data_out3),
      .valid_out0 (valid_out0),
      .valid_out1 (valid_out1),
      .valid_out2 (valid_out2),
      .valid_out3 (valid_out3),
      .pop0       (pop_v[0]),
      .pop1       (pop_v[1]),
      .pop2       (pop_v[2]),
      .pop3       (pop_v[3])
`ifdef DEMUX_STATS_EN
      ,
      .stat_count0 (stat_count0),
      .stat_count1 (stat_count1),
      .stat_count2 (stat_count2),
      .stat_count3 (stat_count3)
`endif
   );

   assign dout[0] = data_out0;
   assign dout[1] = data_out1;
   assign dout[2] = data_out2;
   assign dout[3] = data_out3;
   assign vout[0] = valid_out0;
   assign vout[1] = valid_out1;
   assign vout[2] = valid_out2;
   assign vout[3] = valid_out3;

   // Advance one edge, updating the model from the inputs sampled at that edge.
   task automatic step();
      logic [1:0] ln;
      bit         acc;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mdl[i].delete();
            cnt[i] = 0;
         end
      end else begin
         ln  = data_in[W-1:W-2];
         acc = valid_in && (mdl[ln].size() < D);
         for (int i = 0; i < 4; i++)
            if (pop_v[i] && mdl[i].size() > 0) void'(mdl[i].pop_front());
         if (acc) begin
            mdl[ln].push_back(data_in);
            if (cnt[ln] < 16'hFFFF) cnt[ln]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vout[i] !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_valid%0d got=%b exp=0", i, vout[i]);
         end
      end
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (ready_in !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", ready_in);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vout[i] !== 1'b0 || dout[i] !== '0) begin
            failures++;
            $display("FAIL reset_lane%0d valid=%b data=%h exp valid=0 data=000", i, vout[i], dout[i]);
         end
      end
   endtask

   task automatic test_lanes();
      logic [W-1:0] w [4];
      w[0] = 12'h001; w[1] = 12'h402; w[2] = 12'h803; w[3] = 12'hC04;
      for (int i = 0; i < 4; i++) begin
         data_in  = w[i];
         valid_in = 1'b1;
         #1;
         checks++;
         if (ready_in !== 1'b1) begin
            failures++;
            $display("FAIL lanes_ready%0d got=%b exp=1", i, ready_in);
         end
         step();
         checks++;
         if (vout[i] !== 1'b1 || dout[i] !== w[i]) begin
            failures++;
            $display("FAIL lanes_out%0d valid=%b data=%h exp valid=1 data=%h", i, vout[i], dout[i], w[i]);
         end
      end
      valid_in = 1'b0;
      pop_v    = 4'hF;
      step();
      pop_v    = 4'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vout[i] !== 1'b0 || dout[i] !== '0) begin
            failures++;
            $display("FAIL lanes_drain%0d valid=%b data=%h exp valid=0 data=000", i, vout[i], dout[i]);
         end
      end
   endtask

   task automatic test_full();
      logic [W-1:0] exp;
      for (int k = 0; k < 5; k++) begin
         data_in  = 12'(12'h800 + k + 1);
         valid_in = 1'b1;
         #1;
         checks++;
         if (ready_in !== (k < 4)) begin
            failures++;
            $display("FAIL full_ready%0d got=%b exp=%b", k, ready_in, (k < 4));
         end
         step();
      end
      // Readiness must not depend on valid_in.
      valid_in = 1'b0;
      data_in  = 12'h8FF;
      #1;
      checks++;
      if (ready_in !== 1'b0) begin
         failures++;
         $display("FAIL full_ready_novalid got=%b exp=0", ready_in);
      end
      // Another lane is still open while lane 2 is full.
      data_in  = 12'h001;
      valid_in = 1'b1;
      #1;
      checks++;
      if (ready_in !== 1'b1) begin
         failures++;
         $display("FAIL full_other_ready got=%b exp=1", ready_in);
      end
      step();
      checks++;
      if (vout[0] !== 1'b1 || dout[0] !== 12'h001) begin
         failures++;
         $display("FAIL full_other_out valid=%b data=%h exp valid=1 data=001", vout[0], dout[0]);
      end
      // Full lane popping on the same edge still refuses the new word.
      data_in  = 12'h8EE;
      pop_v    = 4'b0100;
      #1;
      checks++;
      if (ready_in !== 1'b0) begin
         failures++;
         $display("FAIL full_nobypass got=%b exp=0", ready_in);
      end
      step();
      valid_in = 1'b0;
      pop_v    = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         exp = mdl[2][0];
         checks++;
         if (dout[2] !== exp || exp !== 12'(12'h802 + k)) begin
            failures++;
            $display("FAIL full_order%0d got=%h exp=%h", k, dout[2], 12'(12'h802 + k));
         end
         step();
         pop_v = 4'b0100;
      end
      pop_v = 4'h0;
      checks++;
      if (vout[2] !== 1'b0 || vout[0] !== 1'b0) begin
         failures++;
         $display("FAIL full_empty valid2=%b valid0=%b exp 0 0", vout[2], vout[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] seq [3];
      seq[0] = 12'h411; seq[1] = 12'h422; seq[2] = 12'h4AA;
      valid_in = 1'b1;
      data_in  = seq[0]; step();
      data_in  = seq[1]; step();
      // Push and pop together on a non-full lane.
      data_in  = seq[2];
      pop_v    = 4'b0010;
      #1;
      checks++;
      if (ready_in !== 1'b1 || dout[1] !== seq[0]) begin
         failures++;
         $display("FAIL b2b_push_pop ready=%b head=%h exp ready=1 head=%h", ready_in, dout[1], seq[0]);
      end
      step();
      valid_in = 1'b0;
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (vout[1] !== 1'b1 || dout[1] !== seq[k] || dout[1] !== mdl[1][0]) begin
            failures++;
            $display("FAIL b2b_order%0d valid=%b got=%h exp=%h", k, vout[1], dout[1], seq[k]);
         end
         step();
      end
      pop_v = 4'h0;
      checks++;
      if (vout[1] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_occupancy valid1=%b exp=0", vout[1]);
      end
   endtask

   task automatic test_empty_pop();
      valid_in = 1'b0;
      pop_v    = 4'b1000;
      step();
      pop_v    = 4'h0;
      checks++;
      if (vout[3] !== 1'b0 || dout[3] !== '0) begin
         failures++;
         $display("FAIL empty_pop valid=%b data=%h exp valid=0 data=000", vout[3], dout[3]);
      end
      // A subsequent word still lands normally.
      data_in  = 12'hC5A;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      checks++;
      if (vout[3] !== 1'b1 || dout[3] !== 12'hC5A) begin
         failures++;
         $display("FAIL empty_pop_after valid=%b data=%h exp valid=1 data=C5A", vout[3], dout[3]);
      end
   endtask

   task automatic test_mid_reset();
      valid_in = 1'b1;
      data_in  = 12'h0AB; step();
      data_in  = 12'h8CD; step();
`ifdef DEMUX_STATS_EN
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sc[i] !== 16'(cnt[i])) begin
            failures++;
            $display("FAIL stat_count%0d got=%0d exp=%0d", i, sc[i], cnt[i]);
         end
      end
`endif
      // Word offered with reset high must be dropped.
      data_in = 12'h4EE;
      reset   = 1'b1;
      step();
      reset    = 1'b0;
      valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vout[i] !== 1'b0 || dout[i] !== '0) begin
            failures++;
            $display("FAIL midreset_lane%0d valid=%b data=%h exp valid=0 data=000", i, vout[i], dout[i]);
         end
`ifdef DEMUX_STATS_EN
         checks++;
         if (sc[i] !== 16'h0) begin
            failures++;
            $display("FAIL midreset_stat%0d got=%0d exp=0", i, sc[i]);
         end
`endif
      end
      step();
      checks++;
      if (vout[1] !== 1'b0) begin
         failures++;
         $display("FAIL midreset_discard valid1=%b exp=0", vout[1]);
      end
   endtask

   initial begin
      test_reset();
      test_lanes();
      test_full();
      test_back_to_back();
      test_empty_pop();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
